// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_ctrl : pipeline hazard/flush/stall controller (RUN, FLUSH, DIV_WAIT)
// Optional perf counters under `PIPE_CTRL_PERF_EN.   Revision: 1.0
// ============================================================================
module pipe_ctrl (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_rs1_re_i,
  input  logic        id_rs2_re_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_rd_we_i,
  input  logic        ex_is_load_i,
  input  logic        ex_jump_i,
  input  logic [31:0] ex_jump_addr_i,
  input  logic        ex_div_start_i,
  input  logic        div_done_i,
  input  logic        lsu_req_i,
  input  logic        lsu_gnt_i,
  output logic        stall_pc_o,
  output logic        stall_if_id_o,
  output logic        refresh_if_id_o,
  output logic        stall_id_ex_o,
  output logic        refresh_id_ex_o,
  output logic        jump_o,
  output logic [31:0] jump_addr_o,
  output logic [1:0]  state_o,
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    DIV_WAIT = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   w_mem_stall;
  logic   w_load_use;

  assign w_mem_stall = lsu_req_i & ~lsu_gnt_i;
  assign w_load_use  = ex_is_load_i & ex_rd_we_i & (ex_rd_addr_i != 5'd0) &
                       ((id_rs1_re_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                        (id_rs2_re_i & (id_rs2_addr_i == ex_rd_addr_i)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RUN;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    stall_pc_o      = 1'b0;
    stall_if_id_o   = 1'b0;
    refresh_if_id_o = 1'b0;
    stall_id_ex_o   = 1'b0;
    refresh_id_ex_o = 1'b0;
    jump_o          = 1'b0;
    jump_addr_o     = 32'h0;
    if (state_q != RUN && state_q != FLUSH && state_q != DIV_WAIT) begin
      // Encoding 2'd3 is unreachable; always fall back to RUN.
      state_d = RUN;
      if (w_mem_stall) begin
        stall_pc_o    = 1'b1;
        stall_if_id_o = 1'b1;
        stall_id_ex_o = 1'b1;
      end
    end else if (w_mem_stall) begin
      stall_pc_o    = 1'b1;
      stall_if_id_o = 1'b1;
      stall_id_ex_o = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (ex_jump_i) begin
            jump_o          = 1'b1;
            jump_addr_o     = ex_jump_addr_i;
            refresh_if_id_o = 1'b1;
            refresh_id_ex_o = 1'b1;
            state_d         = FLUSH;
          end else if (ex_div_start_i) begin
            state_d = DIV_WAIT;
          end else if (w_load_use) begin
            stall_pc_o      = 1'b1;
            stall_if_id_o   = 1'b1;
            refresh_id_ex_o = 1'b1;
          end
        end
        FLUSH: begin
          // Drop the fetch already in flight from the synchronous I-RAM.
          refresh_if_id_o = 1'b1;
          state_d         = RUN;
        end
        DIV_WAIT: begin
          if (div_done_i) begin
            state_d = RUN;
          end else begin
            stall_pc_o    = 1'b1;
            stall_if_id_o = 1'b1;
            stall_id_ex_o = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign state_o = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      if (stall_pc_o) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (jump_o)     flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_flush_cnt_o = flush_cnt_q;
`else
  assign perf_stall_cnt_o = 32'h0;
  assign perf_flush_cnt_o = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// Directed vector bench for pipe_ctrl: RUN-state vector table plus
// hand-written jump, divide, priority, reset and perf-counter sequences.
module tb_pipe_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
  logic        id_rs1_re_i, id_rs2_re_i, ex_rd_we_i, ex_is_load_i;
  logic        ex_jump_i, ex_div_start_i, div_done_i, lsu_req_i, lsu_gnt_i;
  logic [31:0] ex_jump_addr_i;
  logic        stall_pc_o, stall_if_id_o, refresh_if_id_o;
  logic        stall_id_ex_o, refresh_id_ex_o, jump_o;
  logic [31:0] jump_addr_o, perf_stall_cnt_o, perf_flush_cnt_o;
  logic [1:0]  state_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  pipe_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_re_i(id_rs1_re_i), .id_rs2_re_i(id_rs2_re_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_we_i(ex_rd_we_i),
    .ex_is_load_i(ex_is_load_i), .ex_jump_i(ex_jump_i),
    .ex_jump_addr_i(ex_jump_addr_i), .ex_div_start_i(ex_div_start_i),
    .div_done_i(div_done_i), .lsu_req_i(lsu_req_i), .lsu_gnt_i(lsu_gnt_i),
    .stall_pc_o(stall_pc_o), .stall_if_id_o(stall_if_id_o),
    .refresh_if_id_o(refresh_if_id_o), .stall_id_ex_o(stall_id_ex_o),
    .refresh_id_ex_o(refresh_id_ex_o), .jump_o(jump_o),
    .jump_addr_o(jump_addr_o), .state_o(state_o),
    .perf_stall_cnt_o(perf_stall_cnt_o), .perf_flush_cnt_o(perf_flush_cnt_o)
  );

  // Control bits packed as {stall_pc, stall_if_id, refresh_if_id, stall_id_ex, refresh_id_ex, jump}
  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_LU    = 6'b110010;
  localparam logic [5:0] C_STALL = 6'b110100;
  localparam logic [5:0] C_JUMP  = 6'b001011;
  localparam logic [5:0] C_FLUSH = 6'b001000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [5:0] ctl,
                         input logic [31:0] addr, input logic [1:0] st);
    chk({name, ".ctl"}, {26'd0, stall_pc_o, stall_if_id_o, refresh_if_id_o,
                         stall_id_ex_o, refresh_id_ex_o, jump_o}, {26'd0, ctl});
    chk({name, ".addr"}, jump_addr_o, addr);
    chk({name, ".state"}, {30'd0, state_o}, {30'd0, st});
  endtask

  task automatic clear_inputs();
    id_rs1_addr_i = 5'd0; id_rs2_addr_i = 5'd0; id_rs1_re_i = 1'b0; id_rs2_re_i = 1'b0;
    ex_rd_addr_i = 5'd0; ex_rd_we_i = 1'b0; ex_is_load_i = 1'b0;
    ex_jump_i = 1'b0; ex_jump_addr_i = 32'h0; ex_div_start_i = 1'b0;
    div_done_i = 1'b0; lsu_req_i = 1'b0; lsu_gnt_i = 1'b0;
  endtask

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       re1, re2, we, ld, req, gnt;
    logic [5:0] exp_ctl;
  } vec_t;

  vec_t vt[11];

  initial begin
    //            name        rs1    rs2    rd     re1   re2   we    ld    req   gnt   expected
    vt[0]  = '{"idle",      5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE};
    vt[1]  = '{"lu_rs2",    5'd0,  5'd5,  5'd5,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, C_LU};
    vt[2]  = '{"lu_rd0",    5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, C_NONE};
    vt[3]  = '{"lu_rs1",    5'd7,  5'd2,  5'd7,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, C_LU};
    vt[4]  = '{"rs1_no_re", 5'd7,  5'd2,  5'd7,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, C_NONE};
    vt[5]  = '{"not_load",  5'd7,  5'd7,  5'd7,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE};
    vt[6]  = '{"no_we",     5'd7,  5'd7,  5'd7,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_NONE};
    vt[7]  = '{"addr_diff", 5'd3,  5'd5,  5'd4,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, C_NONE};
    vt[8]  = '{"memst_lu",  5'd5,  5'd0,  5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, C_STALL};
    vt[9]  = '{"gnt_lu",    5'd5,  5'd0,  5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, C_LU};
    vt[10] = '{"lu_r31",    5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, C_LU};

    clear_inputs();
    rst_ni = 1'b0;
    #1;
    chk_out("reset", C_NONE, 32'h0, 2'd0);
    chk("reset.stall_cnt", perf_stall_cnt_o, 32'h0);
    chk("reset.flush_cnt", perf_flush_cnt_o, 32'h0);
    @(negedge clk_i); @(negedge clk_i);
    rst_ni = 1'b1;

    // RUN-state combinational vectors (none of these leave RUN)
    for (int i = 0; i < 11; i++) begin
      @(negedge clk_i);
      clear_inputs();
      id_rs1_addr_i = vt[i].rs1; id_rs2_addr_i = vt[i].rs2; ex_rd_addr_i = vt[i].rd;
      id_rs1_re_i = vt[i].re1; id_rs2_re_i = vt[i].re2; ex_rd_we_i = vt[i].we;
      ex_is_load_i = vt[i].ld; lsu_req_i = vt[i].req; lsu_gnt_i = vt[i].gnt;
      #1;
      chk_out(vt[i].name, vt[i].exp_ctl, 32'h0, 2'd0);
    end

    // Jump then one flush cycle; jump/div inputs ignored while in FLUSH
    @(negedge clk_i); clear_inputs();
    ex_jump_i = 1'b1; ex_jump_addr_i = 32'h0000_0100;
    #1; chk_out("jump.c0", C_JUMP, 32'h100, 2'd0);
    @(negedge clk_i); ex_div_start_i = 1'b1;
    #1; chk_out("jump.c1", C_FLUSH, 32'h0, 2'd1);
    @(negedge clk_i); clear_inputs();
    #1; chk_out("jump.c2", C_NONE, 32'h0, 2'd0);

    // mem_stall holds FLUSH
    @(negedge clk_i); ex_jump_i = 1'b1; ex_jump_addr_i = 32'hDEAD_BEE0;
    #1; chk_out("jmp2.c0", C_JUMP, 32'hDEAD_BEE0, 2'd0);
    @(negedge clk_i); clear_inputs(); lsu_req_i = 1'b1;
    #1; chk_out("flush_memst", C_STALL, 32'h0, 2'd1);
    @(negedge clk_i); clear_inputs();
    #1; chk_out("flush_after", C_FLUSH, 32'h0, 2'd1);

    // Divide: no stall at issue, 4 stall cycles, release on done
    @(negedge clk_i); ex_div_start_i = 1'b1;
    #1; chk_out("div.issue", C_NONE, 32'h0, 2'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i); clear_inputs();
      #1; chk_out($sformatf("div.wait%0d", k), C_STALL | 6'b000000, 32'h0, 2'd2);
    end
    @(negedge clk_i); div_done_i = 1'b1;
    #1; chk_out("div.done", C_NONE, 32'h0, 2'd2);
    @(negedge clk_i); clear_inputs();
    #1; chk_out("div.back", C_NONE, 32'h0, 2'd0);

    // Priority: mem_stall over jump for 3 cycles, jump taken on grant
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i); clear_inputs();
      lsu_req_i = 1'b1; ex_jump_i = 1'b1; ex_jump_addr_i = 32'h0000_2000;
      #1; chk_out($sformatf("prio.st%0d", k), C_STALL, 32'h0, 2'd0);
    end
    @(negedge clk_i); lsu_gnt_i = 1'b1;
    #1; chk_out("prio.gnt", C_JUMP, 32'h2000, 2'd0);
    @(negedge clk_i); clear_inputs();
    #1; chk_out("prio.flush", C_FLUSH, 32'h0, 2'd1);

    // Jump beats divide start in RUN
    @(negedge clk_i); clear_inputs();
    ex_jump_i = 1'b1; ex_div_start_i = 1'b1; ex_jump_addr_i = 32'h44;
    #1; chk_out("jmp_div", C_JUMP, 32'h44, 2'd0);
    @(negedge clk_i); clear_inputs();
    #1; chk_out("jmp_div.c1", C_FLUSH, 32'h0, 2'd1);

    // Reset in DIV_WAIT abandons the divide
    @(negedge clk_i); ex_div_start_i = 1'b1;
    @(negedge clk_i); clear_inputs();
    #1; chk_out("rstdiv.wait", C_STALL, 32'h0, 2'd2);
    @(negedge clk_i); rst_ni = 1'b0;
    #1; chk_out("rstdiv.rst", C_NONE, 32'h0, 2'd0);
    chk("rstdiv.stall_cnt", perf_stall_cnt_o, 32'h0);
    chk("rstdiv.flush_cnt", perf_flush_cnt_o, 32'h0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(negedge clk_i); div_done_i = 1'b1;
    #1; chk_out("rstdiv.late_done", C_NONE, 32'h0, 2'd0);
    @(negedge clk_i); clear_inputs();
    #1; chk_out("rstdiv.after", C_NONE, 32'h0, 2'd0);

    // Perf counters: 3 jumps plus 5 stall cycles from a fresh reset
    @(negedge clk_i); rst_ni = 1'b0;
    @(negedge clk_i); rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i); ex_jump_i = 1'b1; ex_jump_addr_i = 32'h80;
      @(negedge clk_i); clear_inputs();
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i); lsu_req_i = 1'b1;
    end
    @(negedge clk_i); clear_inputs();
    #1;
`ifdef PIPE_CTRL_PERF_EN
    chk("perf.flush_cnt", perf_flush_cnt_o, 32'd3);
    chk("perf.stall_cnt", perf_stall_cnt_o, 32'd5);
`else
    chk("perf.flush_cnt", perf_flush_cnt_o, 32'd0);
    chk("perf.stall_cnt", perf_stall_cnt_o, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
